compare_arbiter: RTL and testbench

//  Shares one Comparator datapath among NREQ requesters. Round-robin arbiter

---
 rtl/compare_pkg.sv | 21 ++
 rtl/comparator.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/compare_arbiter.sv | 124 ++++++++++++
 tb/tb_compare_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/compare_pkg.sv
// Shared types for the compare arbiter and the consumers of its flags.
// Flag bit positions define the layout of rsp_flags.
package compare_pkg;

   localparam int FLAG_W = 6;

   localparam int EQ  = 0;
   localparam int NEQ = 1;
   localparam int LT  = 2;
   localparam int LTE = 3;
   localparam int GT  = 4;
   localparam int GTE = 5;

   typedef logic [FLAG_W-1:0] cmp_flags_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator, full operand width.
// Produces all six relations so consumers need no extra decode.
module comparator #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq,
   output logic             neq,
   output logic             lt,
   output logic             lte,
   output logic             gt,
   output logic             gte
);

   // one of lt/eq/gt, the rest derived
   always_comb begin
      eq  = (a == b);
      lt  = (a < b);
      neq = ~eq;
      lte = lt | eq;
      gt  = ~lte;
      gte = ~lt;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the pointer register lives in the parent.
// Scans ptr, ptr+1, ... wrapping, and grants the first pending request.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt
);

   int   idx;
   logic found;

   // first pending request at or after ptr, modulo N
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/compare_arbiter.sv
// Shares one comparator among NREQ requesters with round-robin arbitration.
// Result is held in a one-deep slot drained through a valid/ready port.
module compare_arbiter
   import compare_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREQ  = 4,
   localparam int ID_W  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [FLAG_W-1:0]     rsp_flags,
   input  logic                  rsp_ready
);

   slot_state_t      state_q;
   slot_state_t      state_d;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  ptr_nxt;
   logic [ID_W-1:0]  win_id;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic             slot_free;
   logic             arb_en;
   logic             grant;
   cmp_flags_t       cmp_flags;
   logic             f_eq;
   logic             f_neq;
   logic             f_lt;
   logic             f_lte;
   logic             f_gt;
   logic             f_gte;

   assign slot_free = (state_q == EMPTY) | rsp_ready;
   assign arb_en    = rst_n & slot_free;
   assign grant     = |gnt;

   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .en  (arb_en),
      .gnt (gnt)
   );

   // one-hot grant to winner index and operand mux
   always_comb begin
      win_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) win_id = ID_W'(i);
      end
      win_a = a_in[int'(win_id)*WIDTH +: WIDTH];
      win_b = b_in[int'(win_id)*WIDTH +: WIDTH];
   end

   comparator #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a   (win_a),
      .b   (win_b),
      .eq  (f_eq),
      .neq (f_neq),
      .lt  (f_lt),
      .lte (f_lte),
      .gt  (f_gt),
      .gte (f_gte)
   );

   // pack comparator outputs and compute the pointer after the winner
   always_comb begin
      cmp_flags      = '0;
      cmp_flags[EQ]  = f_eq;
      cmp_flags[NEQ] = f_neq;
      cmp_flags[LT]  = f_lt;
      cmp_flags[LTE] = f_lte;
      cmp_flags[GT]  = f_gt;
      cmp_flags[GTE] = f_gte;
      if (int'(win_id) == NREQ - 1) ptr_nxt = '0;
      else                          ptr_nxt = win_id + ID_W'(1);
   end

   // slot state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // slot next state and valid output
   always_comb begin
      state_d   = state_q;
      rsp_valid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (grant) state_d = FULL;
         end
         FULL: begin
            rsp_valid = 1'b1;
            if (rsp_ready && !grant) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // capture winner result and advance fairness pointer on grant only
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_id    <= '0;
         rsp_flags <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         rsp_id    <= win_id;
         rsp_flags <= cmp_flags;
         rr_ptr    <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter with a slot-level reference model.
// Model checks every cycle; literal expectations pin key scenarios.
module tb_compare_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] a_in = '0;
   logic [N*W-1:0] b_in = '0;
   logic           rsp_ready = 1'b0;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [5:0]     rsp_flags;

   int n_vec = 0;
   int n_err = 0;

   // reference model state: the result slot and the fairness pointer
   bit       m_valid = 0;
   int       m_id    = 0;
   bit [5:0] m_flags = '0;
   int       m_ptr   = 0;

   always #5 clk = ~clk;

   compare_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_flags (rsp_flags),
      .rsp_ready (rsp_ready)
   );

   function automatic bit [5:0] rel(int a, int b);
      return {a >= b, a > b, a <= b, a < b, a != b, a == b};
   endfunction

   function automatic int winner();
      if (!rst_n) return -1;
      if (m_valid && !rsp_ready) return -1;
      for (int i = 0; i < N; i++) begin
         if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model advances on each rising edge
   always @(posedge clk) begin
      int w;
      w = winner();
      if (!rst_n) begin
         m_valid <= 0;
         m_id    <= 0;
         m_flags <= '0;
         m_ptr   <= 0;
      end else if (w >= 0) begin
         m_valid <= 1;
         m_id    <= w;
         m_flags <= rel(int'(a_in[w*W +: W]), int'(b_in[w*W +: W]));
         m_ptr   <= (w + 1) % N;
      end else if (m_valid && rsp_ready) begin
         m_valid <= 0;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      int w;
      logic [N-1:0] eg;
      w  = winner();
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("model_gnt", int'(gnt), int'(eg));
      chk("model_valid", int'(rsp_valid), int'(m_valid));
      chk("model_id", int'(rsp_id), m_id);
      chk("model_flags", int'(rsp_flags), int'(m_flags));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic one(int idx, int a, int b, int ef);
      req       = '0;
      req[idx]  = 1'b1;
      a_in[idx*W +: W] = W'(a);
      b_in[idx*W +: W] = W'(b);
      rsp_ready = 1'b1;
      look();
      chk("bnd_gnt", int'(gnt), 1 << idx);
      step();
      req = '0;
      look();
      chk("bnd_id", int'(rsp_id), idx);
      chk("bnd_flags", int'(rsp_flags), ef);
      step();
   endtask

   initial begin
      // reset held two edges with all requests pending
      req = 4'b1111;
      step();
      step();
      look();
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_valid", int'(rsp_valid), 0);
      chk("rst_flags", int'(rsp_flags), 0);
      rst_n = 1'b1;
      #1;
      chk("rst_first_gnt", int'(gnt), 4'b0001);
      step();
      req = '0;

      // single request, a=3 b=7
      req = 4'b0100;
      a_in[2*W +: W] = 8'd3;
      b_in[2*W +: W] = 8'd7;
      rsp_ready = 1'b1;
      look();
      chk("single_gnt", int'(gnt), 4'b0100);
      step();
      req = '0;
      look();
      chk("single_valid", int'(rsp_valid), 1);
      chk("single_id", int'(rsp_id), 2);
      chk("single_flags", int'(rsp_flags), 6'b001110);

      // round robin from a fresh pointer
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_in[i*W +: W] = W'(i * 10);
         b_in[i*W +: W] = 8'd20;
      end
      req = 4'b1111;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         look();
         chk("rr_gnt", int'(gnt), 1 << (k % 4));
         if (k > 0) begin
            chk("rr_valid", int'(rsp_valid), 1);
            chk("rr_id", int'(rsp_id), (k - 1) % 4);
         end
         step();
      end

      // back-pressure with id 0 held
      rsp_ready = 1'b0;
      req = 4'b0011;
      for (int k = 0; k < 3; k++) begin
         look();
         chk("bp_gnt", int'(gnt), 0);
         chk("bp_valid", int'(rsp_valid), 1);
         chk("bp_id", int'(rsp_id), 0);
         chk("bp_flags", int'(rsp_flags), 6'b001110);
         step();
      end
      rsp_ready = 1'b1;
      look();
      chk("bp_release_gnt", int'(gnt), 4'b0010);
      step();
      req = '0;
      look();
      chk("bp_next_id", int'(rsp_id), 1);
      chk("bp_next_flags", int'(rsp_flags), 6'b001110);
      step();

      // unsigned boundaries
      one(1, 8'hFF, 8'hFF, 6'b101001);
      one(2, 8'h00, 8'hFF, 6'b001110);
      one(3, 8'h80, 8'h7F, 6'b110010);

      // reset while a result is held under back-pressure
      rsp_ready = 1'b0;
      req = 4'b0001;
      a_in[0 +: W] = 8'd9;
      b_in[0 +: W] = 8'd9;
      step();
      req = 4'b1000;
      a_in[3*W +: W] = 8'd5;
      b_in[3*W +: W] = 8'd1;
      look();
      chk("mid_hold_gnt", int'(gnt), 0);
      chk("mid_hold_valid", int'(rsp_valid), 1);
      rst_n = 1'b0;
      step();
      look();
      chk("mid_rst_valid", int'(rsp_valid), 0);
      chk("mid_rst_gnt", int'(gnt), 0);
      rst_n = 1'b1;
      #1;
      chk("mid_after_gnt", int'(gnt), 4'b1000);
      step();
      req = '0;
      look();
      chk("mid_after_id", int'(rsp_id), 3);
      chk("mid_after_flags", int'(rsp_flags), 6'b110010);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
